// File: rtl/mac_pe_dbuf_if.sv
// Bus bundle for one double-buffered MAC processing element: weight chain,
// activation/partial-sum stream, accumulation control and status.
interface mac_pe_dbuf_if #(
    parameter int A_BITWIDTH = 16,
    parameter int W_BITWIDTH = 8,
    parameter int P_BITWIDTH = 40,
    parameter int CNT_WIDTH  = 8
);
    logic                  w_load;
    logic [W_BITWIDTH-1:0] w_i;
    logic                  w_swap;
    logic [W_BITWIDTH-1:0] w_o;
    logic                  a_valid_i;
    logic [A_BITWIDTH-1:0] a_i;
    logic [P_BITWIDTH-1:0] p_i;
    logic                  a_valid_o;
    logic [A_BITWIDTH-1:0] a_o;
    logic                  p_valid_o;
    logic [P_BITWIDTH-1:0] p_o;
    logic                  acc_mode;
    logic [CNT_WIDTH-1:0]  acc_len;
    logic                  flush;
    logic                  ovf_o;

    modport master (
        output w_load, w_i, w_swap, a_valid_i, a_i, p_i, acc_mode, acc_len, flush,
        input  w_o, a_valid_o, a_o, p_valid_o, p_o, ovf_o
    );

    modport slave (
        input  w_load, w_i, w_swap, a_valid_i, a_i, p_i, acc_mode, acc_len, flush,
        output w_o, a_valid_o, a_o, p_valid_o, p_o, ovf_o
    );
endinterface

// File: rtl/mac_pe_dbuf.sv
// Systolic MAC PE with shadow/active weight double buffer, pass-through or
// local multi-beat accumulation, and saturating partial sums.
module mac_pe_dbuf #(
    parameter int A_BITWIDTH = 16,
    parameter int W_BITWIDTH = 8,
    parameter int P_BITWIDTH = 40,
    parameter int CNT_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    mac_pe_dbuf_if.slave  bus
);
    localparam int PW = A_BITWIDTH + W_BITWIDTH;
    localparam logic signed [P_BITWIDTH-1:0] P_MAX = {1'b0, {(P_BITWIDTH-1){1'b1}}};
    localparam logic signed [P_BITWIDTH-1:0] P_MIN = {1'b1, {(P_BITWIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                        state_q, state_d;
    logic signed [W_BITWIDTH-1:0]  shadow_q, active_q;
    logic [A_BITWIDTH-1:0]         a_q;
    logic                          av_q;
    logic signed [P_BITWIDTH-1:0]  p_q, p_d;
    logic                          pv_q, pv_d;
    logic signed [P_BITWIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]          len_q, len_d;
    logic                          ovf_q, ovf_d;

    logic signed [PW-1:0]          prod;
    logic signed [P_BITWIDTH-1:0]  prod_ext;
    logic [P_BITWIDTH:0]           pass_sum;
    logic [P_BITWIDTH:0]           acc_sum;

    // Result MSB flags saturation; low P_BITWIDTH bits hold the clamped sum.
    function automatic logic [P_BITWIDTH:0] sat_add(
        input logic signed [P_BITWIDTH-1:0] x,
        input logic signed [P_BITWIDTH-1:0] y
    );
        logic [P_BITWIDTH:0] s;
        s = {x[P_BITWIDTH-1], x} + {y[P_BITWIDTH-1], y};
        if (s[P_BITWIDTH] != s[P_BITWIDTH-1]) begin
            return {1'b1, (s[P_BITWIDTH] ? P_MIN : P_MAX)};
        end
        return {1'b0, s[P_BITWIDTH-1:0]};
    endfunction

    always_comb begin
        prod     = $signed(bus.a_i) * active_q;
        prod_ext = P_BITWIDTH'(prod);
        pass_sum = sat_add($signed(bus.p_i), prod_ext);
        acc_sum  = sat_add(acc_q, prod_ext);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        p_d     = '0;
        pv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.a_valid_i) begin
                    if (!bus.acc_mode) begin
                        p_d   = pass_sum[P_BITWIDTH-1:0];
                        pv_d  = 1'b1;
                        ovf_d = ovf_q | pass_sum[P_BITWIDTH];
                    end else if (bus.acc_len <= CNT_WIDTH'(1)) begin
                        p_d  = prod_ext;
                        pv_d = 1'b1;
                    end else begin
                        acc_d   = prod_ext;
                        cnt_d   = CNT_WIDTH'(1);
                        len_d   = bus.acc_len;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (bus.a_valid_i) begin
                    acc_d = acc_sum[P_BITWIDTH-1:0];
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    ovf_d = ovf_q | acc_sum[P_BITWIDTH];
                end
                if (bus.flush || (bus.a_valid_i && (cnt_q + CNT_WIDTH'(1)) == len_q)) begin
                    p_d     = bus.a_valid_i ? acc_sum[P_BITWIDTH-1:0] : acc_q;
                    pv_d    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            a_q      <= '0;
            av_q     <= 1'b0;
            p_q      <= '0;
            pv_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.w_load) shadow_q <= bus.w_i;
            if (bus.w_swap) active_q <= shadow_q;
            a_q   <= bus.a_valid_i ? bus.a_i : '0;
            av_q  <= bus.a_valid_i;
            p_q   <= p_d;
            pv_q  <= pv_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.w_o       = shadow_q;
    assign bus.a_o       = a_q;
    assign bus.a_valid_o = av_q;
    assign bus.p_o       = p_q;
    assign bus.p_valid_o = pv_q;
    assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_mac_pe_dbuf.sv
// Directed bench for mac_pe_dbuf: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_mac_pe_dbuf;
    localparam int A_BITWIDTH = 16;
    localparam int W_BITWIDTH = 8;
    localparam int P_BITWIDTH = 40;
    localparam int CNT_WIDTH  = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mac_pe_dbuf_if #(
        .A_BITWIDTH(A_BITWIDTH), .W_BITWIDTH(W_BITWIDTH),
        .P_BITWIDTH(P_BITWIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    mac_pe_dbuf #(
        .A_BITWIDTH(A_BITWIDTH), .W_BITWIDTH(W_BITWIDTH),
        .P_BITWIDTH(P_BITWIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [A_BITWIDTH-1:0] a, input logic [P_BITWIDTH-1:0] p);
        bus.a_valid_i = 1'b1;
        bus.a_i       = a;
        bus.p_i       = p;
    endtask

    task automatic idle_in();
        bus.a_valid_i = 1'b0;
        bus.a_i       = '0;
        bus.p_i       = '0;
        bus.w_load    = 1'b0;
        bus.w_swap    = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_weight(input logic [W_BITWIDTH-1:0] w);
        idle_in();
        bus.w_load = 1'b1;
        bus.w_i    = w;
        step();
        bus.w_load = 1'b0;
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        bus.w_i      = '0;
        bus.acc_mode = 1'b0;
        bus.acc_len  = '0;
        step();
        step();
        chk("rst_p_o", 64'(bus.p_o), 64'd0);
        chk("rst_p_valid", 64'(bus.p_valid_o), 64'd0);
        chk("rst_a_o", 64'(bus.a_o), 64'd0);
        chk("rst_a_valid", 64'(bus.a_valid_o), 64'd0);
        chk("rst_w_o", 64'(bus.w_o), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
        rst = 1'b0;

        // Pass mode: w=3, a=-5, p=100 -> 85
        bus.w_load = 1'b1; bus.w_i = 8'd3;
        step();
        chk("w_chain", 64'(bus.w_o), 64'd3);
        bus.w_load = 1'b0; bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        beat(16'hFFFB, 40'd100);
        step();
        chk("pass_p_o", 64'(bus.p_o), 64'd85);
        chk("pass_p_valid", 64'(bus.p_valid_o), 64'd1);
        chk("pass_a_o", 64'(bus.a_o), 64'hFFFB);
        chk("pass_a_valid", 64'(bus.a_valid_o), 64'd1);
        idle_in();
        step();
        chk("gap_p_o", 64'(bus.p_o), 64'd0);
        chk("gap_p_valid", 64'(bus.p_valid_o), 64'd0);
        chk("gap_a_o", 64'(bus.a_o), 64'd0);
        chk("gap_a_valid", 64'(bus.a_valid_o), 64'd0);

        // Double buffer: active 2; load 7 + swap + beat uses 2
        set_weight(8'd2);
        bus.w_load = 1'b1; bus.w_i = 8'd7; bus.w_swap = 1'b1;
        beat(16'd4, 40'd10);
        step();
        chk("dbuf_old_w", 64'(bus.p_o), 64'd18);
        chk("dbuf_shadow", 64'(bus.w_o), 64'd7);
        idle_in();
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        beat(16'd4, 40'd10);
        step();
        chk("dbuf_new_w", 64'(bus.p_o), 64'd38);

        // Accumulate len 4, w=2, beats 1,2,gap,3,4 -> 20
        set_weight(8'd2);
        bus.acc_mode = 1'b1; bus.acc_len = 8'd4;
        beat(16'd1, 40'd999);
        step();
        chk("acc_b1_valid", 64'(bus.p_valid_o), 64'd0);
        bus.acc_mode = 1'b0; bus.acc_len = 8'd2;
        beat(16'd2, 40'd999);
        step();
        chk("acc_b2_valid", 64'(bus.p_valid_o), 64'd0);
        idle_in();
        step();
        chk("acc_gap_valid", 64'(bus.p_valid_o), 64'd0);
        beat(16'd3, 40'd999);
        step();
        chk("acc_b3_valid", 64'(bus.p_valid_o), 64'd0);
        beat(16'd4, 40'd999);
        step();
        chk("acc_result", 64'(bus.p_o), 64'd20);
        chk("acc_result_valid", 64'(bus.p_valid_o), 64'd1);
        idle_in();
        step();
        chk("acc_after_valid", 64'(bus.p_valid_o), 64'd0);

        // Single-beat accumulations: acc_len 1 and 0, p_i ignored
        bus.acc_mode = 1'b1; bus.acc_len = 8'd1;
        beat(16'd9, 40'd1000);
        step();
        chk("len1_p_o", 64'(bus.p_o), 64'd18);
        chk("len1_valid", 64'(bus.p_valid_o), 64'd1);
        bus.acc_len = 8'd0;
        beat(16'd5, 40'd1000);
        step();
        chk("len0_p_o", 64'(bus.p_o), 64'd10);

        // Flush: len 8, w=1, beats 5,6 then flush with 7 -> 18
        set_weight(8'd1);
        bus.acc_mode = 1'b1; bus.acc_len = 8'd8;
        beat(16'd5, 40'd0);
        step();
        beat(16'd6, 40'd0);
        step();
        chk("flush_pre_valid", 64'(bus.p_valid_o), 64'd0);
        beat(16'd7, 40'd0);
        bus.flush = 1'b1;
        step();
        chk("flush_p_o", 64'(bus.p_o), 64'd18);
        chk("flush_valid", 64'(bus.p_valid_o), 64'd1);
        idle_in();
        bus.flush = 1'b1;
        step();
        chk("flush_idle_valid", 64'(bus.p_valid_o), 64'd0);
        bus.flush = 1'b0;
        bus.acc_mode = 1'b0;
        beat(16'd3, 40'd50);
        step();
        chk("post_flush_idle", 64'(bus.p_o), 64'd53);
        chk("no_ovf_yet", 64'(bus.ovf_o), 64'd0);

        // Reset mid-accumulation, then a clean restart
        set_weight(8'd2);
        bus.acc_mode = 1'b1; bus.acc_len = 8'd4;
        beat(16'd1, 40'd0);
        step();
        beat(16'd2, 40'd0);
        step();
        rst = 1'b1;
        beat(16'd3, 40'd0);
        step();
        rst = 1'b0;
        chk("mid_rst_p_o", 64'(bus.p_o), 64'd0);
        chk("mid_rst_valid", 64'(bus.p_valid_o), 64'd0);
        chk("mid_rst_a_o", 64'(bus.a_o), 64'd0);
        chk("mid_rst_a_valid", 64'(bus.a_valid_o), 64'd0);
        chk("mid_rst_w_o", 64'(bus.w_o), 64'd0);
        set_weight(8'd2);
        chk("mid_rst_no_pulse", 64'(bus.p_valid_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            beat(16'd1, 40'd0);
            step();
            chk("restart_busy", 64'(bus.p_valid_o), 64'd0);
        end
        beat(16'd1, 40'd0);
        step();
        chk("restart_result", 64'(bus.p_o), 64'd8);
        chk("restart_valid", 64'(bus.p_valid_o), 64'd1);

        // Saturation and sticky overflow
        set_weight(8'd1);
        bus.acc_mode = 1'b0;
        beat(16'd1, 40'h7FFFFFFFFF);
        step();
        chk("sat_pos_p_o", 64'(bus.p_o), 64'h7FFFFFFFFF);
        chk("sat_pos_ovf", 64'(bus.ovf_o), 64'd1);
        beat(16'd1, 40'd5);
        step();
        chk("sat_normal_p_o", 64'(bus.p_o), 64'd6);
        chk("sat_sticky", 64'(bus.ovf_o), 64'd1);
        beat(16'hFFFF, 40'h8000000000);
        step();
        chk("sat_neg_p_o", 64'(bus.p_o), 64'h8000000000);
        idle_in();
        step();
        chk("sat_sticky_idle", 64'(bus.ovf_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
